// File: rtl/hazard_ctrl_mdu.sv
// hazard_ctrl_mdu: forwarding, load-use, branch flush and blocking MDU stall control for a 5-stage RV32 core.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_mdu #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              memReadE,
    input  logic              pcsrcE,
    input  logic              mduStartE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mduBusy,
    output logic              mduDone,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);
    localparam int CW = $clog2(MDU_LAT + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic fwd_m1, fwd_w1, fwd_m2, fwd_w2, lu, mdu_stall;

    assign fwd_m1 = regWriteM && rdM != '0 && rdM == rs1E;
    assign fwd_w1 = regWriteW && rdW != '0 && rdW == rs1E;
    assign fwd_m2 = regWriteM && rdM != '0 && rdM == rs2E;
    assign fwd_w2 = regWriteW && rdW != '0 && rdW == rs2E;
    assign forwardAE = fwd_m1 ? 2'b10 : fwd_w1 ? 2'b01 : 2'b00;
    assign forwardBE = fwd_m2 ? 2'b10 : fwd_w2 ? 2'b01 : 2'b00;

    assign lu = memReadE && rdE != '0 && (rdE == rs1D || rdE == rs2D);
    assign mdu_stall = (state == IDLE) ? mduStartE : (cnt > CW'(1));
    assign mduBusy = (state == BUSY);
    assign mduDone = (state == BUSY) && cnt == CW'(1);

    // MDU stall dominates; a taken branch cancels the load-use stall since Decode is on the wrong path
    assign stallF = mdu_stall || (lu && !pcsrcE);
    assign stallD = stallF;
    assign stallE = mdu_stall;
    assign flushM = mdu_stall;
    assign flushD = !mdu_stall && pcsrcE;
    assign flushE = !mdu_stall && (pcsrcE || lu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (mduStartE) begin
                state <= BUSY;
                cnt   <= CW'(MDU_LAT - 1);
            end
        end else if (cnt > CW'(1)) begin
            cnt <= cnt - 1'b1;
        end else begin
            state <= IDLE;
            cnt   <= '0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] sc, fc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
            fc <= '0;
        end else begin
            if (stallF && sc != '1) sc <= sc + 1'b1;
            if (pcsrcE && fc != '1) fc <= fc + 1'b1;
        end
    end
    assign stallCount = sc;
    assign flushCount = fc;
`else
    assign stallCount = '0;
    assign flushCount = '0;
`endif
endmodule
